// File: rtl/mux_rr_arbiter_pkg.sv
// rtl/mux_rr_arbiter_pkg.sv - shared types and constants for the round-robin mux arbiter
//
// Purpose: FSM state encoding, requester count / index width, and a one-hot helper
//          used by mux_rr_arbiter and rr_pick4.
// Ports:   none (package).
package mux_rr_arbiter_pkg;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    return NUM_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/mux_rr_arbiter_rr_pick4.sv
// rtl/mux_rr_arbiter_rr_pick4.sv - combinational rotating-priority pick among four requests
//
// Purpose: finds the first set request scanning ptr, ptr+1, ... (mod 4), optionally
//          skipping the index given by mask.
// Ports:
//   req     in  [3:0]  request vector
//   ptr     in  [1:0]  highest-priority index for this scan
//   mask    in  [1:0]  index to exclude when mask_en=1 (current owner)
//   mask_en in  1      enable exclusion of mask
//   any     out 1      a candidate was found
//   idx     out [1:0]  winning index (0 when any=0)
module rr_pick4
  import mux_rr_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  input  logic [IDX_W-1:0]   mask,
  input  logic               mask_en,
  output logic               any,
  output logic [IDX_W-1:0]   idx
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    any  = 1'b0;
    idx  = '0;
    cand = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      // Index arithmetic wraps naturally in IDX_W bits.
      cand = ptr + IDX_W'(i);
      if (!any && req[cand] && !(mask_en && (cand == mask))) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// rtl/mux_rr_arbiter.sv - round-robin arbiter driving a shared 4:1 WIDTH-bit mux
//
// Purpose: registers a one-hot grant and the mux select {addr1,addr0}, and gates the
//          selected input onto out. Optional macro MUX_ARB_HOLD_LIMIT_EN limits each
//          owner to HOLD_MAX consecutive cycles when others are waiting.
// Ports:
//   clk        in   1      rising-edge clock
//   reset      in   1      asynchronous active-high reset
//   req        in   [3:0]  request vector
//   in0..in3   in   WIDTH  requester data
//   gnt        out  [3:0]  registered one-hot grant
//   addr0      out  1      registered select LSB
//   addr1      out  1      registered select MSB
//   valid      out  1      registered, grant held
//   out        out  WIDTH  selected data when valid, else 0
module mux_rr_arbiter
  import mux_rr_arbiter_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int HOLD_MAX = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic [WIDTH-1:0]   in0,
  input  logic [WIDTH-1:0]   in1,
  input  logic [WIDTH-1:0]   in2,
  input  logic [WIDTH-1:0]   in3,
  output logic [NUM_REQ-1:0] gnt,
  output logic               addr0,
  output logic               addr1,
  output logic               valid,
  output logic [WIDTH-1:0]   out
);

  // HOLD_MAX must be at least 1; an empty block keeps the parameter referenced in
  // builds without the hold limit.
  if (HOLD_MAX < 1) begin : g_hold_max_invalid
  end

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0]   addr_q, addr_d;
  logic               valid_q, valid_d;

  logic               pick_any;
  logic [IDX_W-1:0]   pick_idx;
  logic               hold_expired;
  logic               take;

`ifdef MUX_ARB_HOLD_LIMIT_EN
  localparam int CNT_W = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;

  assign hold_expired = (hold_cnt_q == HOLD_LAST);
`else
  assign hold_expired = 1'b0;
`endif

  // ptr already equals owner+1, so the scan begins just after the owner; the mask
  // only matters when the owner still requests (forced hand-over on hold limit).
  rr_pick4 u_pick (
    .req     (req),
    .ptr     (ptr_q),
    .mask    (addr_q),
    .mask_en (state_q == ST_GRANT),
    .any     (pick_any),
    .idx     (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    addr_d  = addr_q;
    valid_d = valid_q;
    take    = 1'b0;
`ifdef MUX_ARB_HOLD_LIMIT_EN
    hold_cnt_d = hold_cnt_q;
`endif

    case (state_q)
      ST_IDLE: begin
        take = pick_any;
      end
      ST_GRANT: begin
        if (!req[addr_q] || hold_expired) begin
          if (pick_any) begin
            take = 1'b1;
          end else if (!req[addr_q]) begin
            state_d = ST_IDLE;
            gnt_d   = '0;
            addr_d  = '0;
            valid_d = 1'b0;
`ifdef MUX_ARB_HOLD_LIMIT_EN
            hold_cnt_d = '0;
`endif
          end
        end
`ifdef MUX_ARB_HOLD_LIMIT_EN
        // Owner keeps the bus: count up, saturating at the limit.
        if (!take && state_d == ST_GRANT && !hold_expired) begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
`endif
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (take) begin
      state_d = ST_GRANT;
      gnt_d   = idx_to_onehot(pick_idx);
      addr_d  = pick_idx;
      valid_d = 1'b1;
      ptr_d   = pick_idx + IDX_W'(1);
`ifdef MUX_ARB_HOLD_LIMIT_EN
      hold_cnt_d = '0;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      addr_q  <= '0;
      valid_q <= 1'b0;
`ifdef MUX_ARB_HOLD_LIMIT_EN
      hold_cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
`ifdef MUX_ARB_HOLD_LIMIT_EN
      hold_cnt_q <= hold_cnt_d;
`endif
    end
  end

  assign gnt   = gnt_q;
  assign addr0 = addr_q[0];
  assign addr1 = addr_q[1];
  assign valid = valid_q;

  logic [WIDTH-1:0] mux_sel;

  always_comb begin
    mux_sel = '0;
    case (addr_q)
      2'd0:    mux_sel = in0;
      2'd1:    mux_sel = in1;
      2'd2:    mux_sel = in2;
      default: mux_sel = in3;
    endcase
  end

  assign out = mux_sel & {WIDTH{valid_q}};

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb/tb_mux_rr_arbiter.sv - directed self-checking bench for mux_rr_arbiter
module tb_mux_rr_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [7:0] in0 = 8'h11;
  logic [7:0] in1 = 8'h22;
  logic [7:0] in2 = 8'hA5;
  logic [7:0] in3 = 8'h3C;
  logic [3:0] gnt;
  logic       addr0;
  logic       addr1;
  logic       valid;
  logic [7:0] out;

  int checks = 0;
  int errors = 0;

  mux_rr_arbiter #(.WIDTH(8), .HOLD_MAX(4)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .in0   (in0),
    .in1   (in1),
    .in2   (in2),
    .in3   (in3),
    .gnt   (gnt),
    .addr0 (addr0),
    .addr1 (addr1),
    .valid (valid),
    .out   (out)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = 4'b0000;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req   = 4'b1111;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt cyc %0d got %b exp 0000", c, gnt); end
      checks++; if ({addr1, addr0} !== 2'b00) begin errors++; $display("FAIL reset_addr cyc %0d got %b exp 00", c, {addr1, addr0}); end
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid cyc %0d got %b exp 0", c, valid); end
      checks++; if (out !== 8'h00) begin errors++; $display("FAIL reset_out cyc %0d got %h exp 00", c, out); end
    end
    reset = 1'b0;
    req   = 4'b0000;
    step();
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0100;
    step();
    checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL single_gnt got %b exp 0100", gnt); end
    checks++; if ({addr1, addr0} !== 2'b10) begin errors++; $display("FAIL single_addr got %b exp 10", {addr1, addr0}); end
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", valid); end
    checks++; if (out !== 8'hA5) begin errors++; $display("FAIL single_out got %h exp a5", out); end
    req = 4'b0000;
    step();
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL single_idle_gnt got %b exp 0000", gnt); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL single_idle_valid got %b exp 0", valid); end
    checks++; if (out !== 8'h00) begin errors++; $display("FAIL single_idle_out got %h exp 00", out); end
    checks++; if ({addr1, addr0} !== 2'b00) begin errors++; $display("FAIL single_idle_addr got %b exp 00", {addr1, addr0}); end
  endtask

  task automatic test_round_robin();
    logic [3:0] reqs  [5] = '{4'b1111, 4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [3:0] exp_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [1:0] exp_a [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [7:0] exp_d [5] = '{8'h11, 8'h22, 8'hA5, 8'h3C, 8'h11};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      req = reqs[i];
      step();
      checks++; if (gnt !== exp_g[i]) begin errors++; $display("FAIL rr_gnt step %0d got %b exp %b", i, gnt, exp_g[i]); end
      checks++; if ({addr1, addr0} !== exp_a[i]) begin errors++; $display("FAIL rr_addr step %0d got %b exp %b", i, {addr1, addr0}, exp_a[i]); end
      checks++; if (valid !== 1'b1) begin errors++; $display("FAIL rr_valid step %0d got %b exp 1", i, valid); end
      checks++; if (out !== exp_d[i]) begin errors++; $display("FAIL rr_out step %0d got %h exp %h", i, out, exp_d[i]); end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    req = 4'b0100;
    step();
    checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL wrap_first got %b exp 0100", gnt); end
    req = 4'b0000;
    step();
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL wrap_idle got %b exp 0", valid); end
    req = 4'b1001;
    step();
    checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL wrap_win3 got %b exp 1000", gnt); end
    checks++; if (out !== 8'h3C) begin errors++; $display("FAIL wrap_out3 got %h exp 3c", out); end
    req = 4'b0001;
    step();
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL wrap_win0 got %b exp 0001", gnt); end
    checks++; if ({addr1, addr0} !== 2'b00) begin errors++; $display("FAIL wrap_addr0 got %b exp 00", {addr1, addr0}); end
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    req = 4'b0010;
    step();
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL mid_pre_gnt got %b exp 0010", gnt); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL mid_async_gnt got %b exp 0000", gnt); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL mid_async_valid got %b exp 0", valid); end
    checks++; if (out !== 8'h00) begin errors++; $display("FAIL mid_async_out got %h exp 00", out); end
    checks++; if ({addr1, addr0} !== 2'b00) begin errors++; $display("FAIL mid_async_addr got %b exp 00", {addr1, addr0}); end
    req = 4'b0011;
    #1;
    reset = 1'b0;
    step();
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL mid_post_gnt got %b exp 0001", gnt); end
    // Pointer must restart at 0: after owning 1 (ptr=2), reset, then 1 and 2 compete.
    do_reset();
    req = 4'b0010;
    step();
    reset = 1'b1;
    #2;
    req = 4'b0110;
    reset = 1'b0;
    step();
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL mid_ptr_gnt got %b exp 0010", gnt); end
  endtask

`ifdef MUX_ARB_HOLD_LIMIT_EN
  task automatic test_hold_limit();
    logic [3:0] exp;
    do_reset();
    req = 4'b0011;
    for (int c = 1; c <= 12; c++) begin
      step();
      exp = ((((c - 1) / 4) % 2) == 0) ? 4'b0001 : 4'b0010;
      checks++; if (gnt !== exp) begin errors++; $display("FAIL hold_alt cyc %0d got %b exp %b", c, gnt, exp); end
    end
    req = 4'b0001;
    for (int c = 0; c < 8; c++) begin
      step();
      checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL hold_alone cyc %0d got %b exp 0001", c, gnt); end
    end
  endtask
`else
  task automatic test_hold_limit();
    do_reset();
    req = 4'b0011;
    for (int c = 1; c <= 12; c++) begin
      step();
      checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL nohold_keep cyc %0d got %b exp 0001", c, gnt); end
    end
    req = 4'b0010;
    step();
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL nohold_handover got %b exp 0010", gnt); end
    checks++; if (out !== 8'h22) begin errors++; $display("FAIL nohold_out got %h exp 22", out); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_reset_mid_grant();
    test_hold_limit();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
